// File: rtl/fixed_point_mul_arbiter_pkg.sv
// Shared types for the fixed-point multiplier arbiter: Q16.16 fixed-point
// number format and the operand payload carried by the first pipeline stage.
package fixed_point_mul_arbiter_pkg;

  localparam int FIXED_W          = 32;
  localparam int FIXED_FRACTION_W = 16;

  typedef logic signed [FIXED_W-1:0] fixed_point_t;

  typedef struct packed {
    fixed_point_t op1;
    fixed_point_t op2;
  } mul_stage_t;

endpackage

// File: rtl/fixed_point_mul_arbiter_if.sv
// Request/response bus between the requesters, the response consumer and the
// shared multiplier. The arbiter connects through the slave modport.
interface fixed_point_mul_arbiter_if #(
  parameter int N_REQ = 4
);
  import fixed_point_mul_arbiter_pkg::*;

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]         req_valid;
  fixed_point_t [N_REQ-1:0] req_op1;
  fixed_point_t [N_REQ-1:0] req_op2;
  logic [N_REQ-1:0]         req_ready;

  logic                     resp_valid;
  logic                     resp_ready;
  logic [ID_W-1:0]          resp_id;
  fixed_point_t             resp_result;
  logic                     resp_overflow;

  modport master (
    output req_valid, req_op1, req_op2, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );

  modport slave (
    input  req_valid, req_op1, req_op2, resp_ready,
    output req_ready, resp_valid, resp_id, resp_result, resp_overflow
  );

endinterface

// File: rtl/fixed_point_mul_arbiter_mul.sv
// Combinational signed fixed-point multiplier. The full-width product is
// rescaled by the fraction width and truncated; overflow flags any product
// whose rescaled value does not fit the fixed-point format.
module fixed_point_mul
  import fixed_point_mul_arbiter_pkg::*;
(
  input  fixed_point_t a,
  input  fixed_point_t b,
  output fixed_point_t result,
  output logic         overflow
);

  logic signed [2*FIXED_W-1:0] full;
  logic signed [2*FIXED_W-1:0] shifted;

  // Sign-extend both operands so the low 2*FIXED_W bits are the exact product
  assign full    = $signed({{FIXED_W{a[FIXED_W-1]}}, a}) * $signed({{FIXED_W{b[FIXED_W-1]}}, b});
  assign shifted = full >>> FIXED_FRACTION_W;
  assign result  = shifted[FIXED_W-1:0];

  // Representable only if every bit above the result sign bit copies it
  assign overflow = !((&shifted[2*FIXED_W-1:FIXED_W-1]) || !(|shifted[2*FIXED_W-1:FIXED_W-1]));

endmodule

// File: rtl/fixed_point_mul_arbiter_rr_arbiter.sv
// Generic round-robin arbiter. Searches from the entry after the last winner,
// wrapping by explicit compare so any N (not just powers of two) works.
// The pointer only moves when the caller reports that the grant was taken.
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  // Pick the first requesting index after ptr, wrapping modulo N
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= N; off++) begin
      cand = int'(ptr) + off;
      if (cand >= N) cand = cand - N;
      if (!found && req[IDX_W'(cand)]) begin
        found                 = 1'b1;
        grant[IDX_W'(cand)]   = 1'b1;
        grant_idx             = IDX_W'(cand);
      end
    end
  end

  // Remember the last winner; reset to N-1 so index 0 has first priority
  always_ff @(posedge clk) begin
    if (reset) ptr <= IDX_W'(N - 1);
    else if (advance) ptr <= grant_idx;
  end

endmodule

// File: rtl/fixed_point_mul_arbiter.sv
// Shares one combinational fixed-point multiplier between N_REQ requesters.
// Round-robin grant feeds an operand register (S1); the multiplier sits
// between S1 and the result register (S2), which drives the tagged response.
// A sticky flag records any overflowing response that was consumed.
module fixed_point_mul_arbiter
  import fixed_point_mul_arbiter_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int ID_W  = $clog2(N_REQ)
) (
  input  logic                      clk,
  input  logic                      reset,
  fixed_point_mul_arbiter_if.slave  bus,
  input  logic                      ovf_clear,
  output logic                      ovf_sticky,
  output logic                      busy
);

  logic             s1_valid;
  mul_stage_t       s1_data;
  logic [ID_W-1:0]  s1_id;

  logic             s2_valid;
  fixed_point_t     s2_result;
  logic             s2_overflow;
  logic [ID_W-1:0]  s2_id;

  logic             s1_en;
  logic             s2_en;
  logic             handshake;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;

  fixed_point_t     mul_result;
  logic             mul_overflow;

  // A stage may load when it is empty or its contents move on this edge
  assign s2_en     = !s2_valid || bus.resp_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign bus.req_ready = grant & {N_REQ{s1_en}};
  assign handshake = s1_en && (|grant);

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (bus.req_valid),
    .advance   (handshake),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  fixed_point_mul u_mul (
    .a        (s1_data.op1),
    .b        (s1_data.op2),
    .result   (mul_result),
    .overflow (mul_overflow)
  );

  // Operand stage: capture the granted requester's operands and tag
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
    end else if (s1_en) begin
      s1_valid <= handshake;
      if (handshake) begin
        s1_data.op1 <= bus.req_op1[grant_idx];
        s1_data.op2 <= bus.req_op2[grant_idx];
        s1_id       <= grant_idx;
      end
    end
  end

  // Result stage: register the product; holds while the consumer stalls
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      s2_result   <= '0;
      s2_overflow <= 1'b0;
      s2_id       <= '0;
    end else if (s2_en) begin
      s2_valid    <= s1_valid;
      s2_result   <= mul_result;
      s2_overflow <= mul_overflow;
      s2_id       <= s1_id;
    end
  end

  // Sticky overflow: a consumed overflowing response beats a clear
  always_ff @(posedge clk) begin
    if (reset) ovf_sticky <= 1'b0;
    else if (s2_valid && bus.resp_ready && s2_overflow) ovf_sticky <= 1'b1;
    else if (ovf_clear) ovf_sticky <= 1'b0;
  end

  assign bus.resp_valid    = s2_valid;
  assign bus.resp_id       = s2_id;
  assign bus.resp_result   = s2_result;
  assign bus.resp_overflow = s2_overflow;
  assign busy              = s1_valid || s2_valid;

endmodule

// File: tb/tb_fixed_point_mul_arbiter.sv
// Scoreboard bench for fixed_point_mul_arbiter (N_REQ=4, Q16.16).
// Accepted requests push hand-computed expected responses; a separate
// monitor pops and compares whenever a response handshake occurs.
module tb_fixed_point_mul_arbiter;

  typedef struct {
    int          id;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic ovf_clear;
  logic ovf_sticky;
  logic busy;

  fixed_point_mul_arbiter_if #(.N_REQ(4)) bus();

  fixed_point_mul_arbiter #(.N_REQ(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .ovf_clear  (ovf_clear),
    .ovf_sticky (ovf_sticky),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  exp_t        sb[$];
  int          acc_log[$];
  int          checks = 0;
  int          passes = 0;
  int          model_ptr = 3;

  logic [31:0] op1_tab[4];
  logic [31:0] op2_tab[4];
  logic [31:0] res_tab[4];
  logic        ovf_tab[4];

  logic [3:0]  acc_hs;
  int          acc_g;

  logic        prev_valid = 1'b0;
  logic        prev_ready = 1'b0;
  logic [31:0] prev_id;
  logic [31:0] prev_res;
  logic        prev_ovf;
  exp_t        cur;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("[TB] FAIL %s: got %h, want %h", name, act, expv);
  endtask

  task automatic applyStimulus(input logic [3:0] valid);
    bus.req_valid = valid;
    for (int i = 0; i < 4; i++) begin
      bus.req_op1[i] = op1_tab[i];
      bus.req_op2[i] = op2_tab[i];
    end
  endtask

  task automatic loadNormalTables();
    op1_tab[0] = 32'h0001_8000; op2_tab[0] = 32'h0002_0000; res_tab[0] = 32'h0003_0000; ovf_tab[0] = 1'b0;
    op1_tab[1] = 32'h0001_0000; op2_tab[1] = 32'hFFFF_0000; res_tab[1] = 32'hFFFF_0000; ovf_tab[1] = 1'b0;
    op1_tab[2] = 32'h0000_8000; op2_tab[2] = 32'h0000_8000; res_tab[2] = 32'h0000_4000; ovf_tab[2] = 1'b0;
    op1_tab[3] = 32'h0003_0000; op2_tab[3] = 32'h0002_8000; res_tab[3] = 32'h0007_8000; ovf_tab[3] = 1'b0;
  endtask

  function automatic int modelGrant(input logic [3:0] v, input int p);
    for (int off = 1; off <= 4; off++) begin
      if (v[(p + off) % 4]) return (p + off) % 4;
    end
    return 0;
  endfunction

  task automatic waitAccept(input int idx, input int bound);
    int n = 0;
    @(negedge clk);
    while (!bus.req_ready[idx] && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready[idx]) begin
      checks++;
      $display("[TB] FAIL accept_timeout: req_ready[%0d] got 0, want 1 within %0d cycles", idx, bound);
    end
  endtask

  task automatic waitResp(input int bound);
    int n = 0;
    @(negedge clk);
    while (!bus.resp_valid && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (!bus.resp_valid) begin
      checks++;
      $display("[TB] FAIL resp_timeout: resp_valid got 0, want 1 within %0d cycles", bound);
    end
  endtask

  task automatic waitDrain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 32'(sb.size()), 32'd0);
  endtask

  // Accept monitor: check grant against a round-robin model, push expectation
  always @(negedge clk) begin
    if (!reset) begin
      acc_hs = bus.req_valid & bus.req_ready;
      if (acc_hs != 4'b0) begin
        acc_g = modelGrant(bus.req_valid, model_ptr);
        checkOutput("grant", {28'b0, bus.req_ready}, 32'd1 << acc_g);
        for (int i = 0; i < 4; i++) if (acc_hs[i]) acc_log.push_back(i);
        sb.push_back('{acc_g, res_tab[acc_g], ovf_tab[acc_g]});
        model_ptr = acc_g;
      end
    end
  end

  // Response monitor: stability under stall and in-order scoreboard compare
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (prev_valid && !prev_ready) begin
        checkOutput("stall_valid", 32'(bus.resp_valid), 32'd1);
        checkOutput("stall_id", 32'(bus.resp_id), prev_id);
        checkOutput("stall_result", bus.resp_result, prev_res);
        checkOutput("stall_overflow", 32'(bus.resp_overflow), 32'(prev_ovf));
      end
      if (bus.resp_valid && bus.resp_ready) begin
        if (sb.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_resp: got id %0d result %h, want no response", bus.resp_id, bus.resp_result);
        end else begin
          cur = sb.pop_front();
          checkOutput("resp_id", 32'(bus.resp_id), 32'(cur.id));
          checkOutput("resp_result", bus.resp_result, cur.res);
          checkOutput("resp_overflow", 32'(bus.resp_overflow), 32'(cur.ovf));
        end
      end
      prev_valid = bus.resp_valid;
      prev_ready = bus.resp_ready;
      prev_id    = 32'(bus.resp_id);
      prev_res   = bus.resp_result;
      prev_ovf   = bus.resp_overflow;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, want $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t3_ids[6];
    int acc_before;
    t3_ids = '{0, 1, 2, 3, 0, 1};

    reset          = 1'b1;
    ovf_clear      = 1'b0;
    bus.resp_ready = 1'b1;
    loadNormalTables();
    applyStimulus(4'b0000);

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_ovf_sticky", 32'(ovf_sticky), 32'd0);
    checkOutput("reset_req_ready", 32'(bus.req_ready), 32'd0);
    checkOutput("reset_resp_id", 32'(bus.resp_id), 32'd0);
    checkOutput("reset_resp_result", bus.resp_result, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Round-robin stream starting from requester 0
    acc_log.delete();
    applyStimulus(4'b1111);
    repeat (6) @(posedge clk);
    #1;
    applyStimulus(4'b0000);
    checkOutput("rr_count", 32'(acc_log.size()), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < acc_log.size()) checkOutput("rr_order", 32'(acc_log[i]), 32'(t3_ids[i]));
    end
    waitDrain(20);

    // Single request latency: 1.5 * 2.0 from requester 0
    @(posedge clk); #1;
    applyStimulus(4'b0001);
    waitAccept(0, 10);
    @(posedge clk); #1;
    applyStimulus(4'b0000);
    @(negedge clk);
    checkOutput("lat_t1_resp_valid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    checkOutput("lat_t2_resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("lat_t2_result", bus.resp_result, 32'h0003_0000);
    waitDrain(20);

    // Backpressure: stall a full pipeline for 5 cycles
    @(posedge clk); #1;
    applyStimulus(4'b1111);
    repeat (4) @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
    acc_before = acc_log.size();
    repeat (5) begin
      @(negedge clk);
      checkOutput("stall_req_ready", 32'(bus.req_ready), 32'd0);
      checkOutput("stall_busy", 32'(busy), 32'd1);
    end
    @(posedge clk); #1;
    checkOutput("stall_no_accept", 32'(acc_log.size()), 32'(acc_before));
    bus.resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(4'b0000);
    waitDrain(20);

    // Overflow and sticky flag
    op1_tab[0] = 32'h7FFF_0000; op2_tab[0] = 32'h0002_0000;
    res_tab[0] = 32'hFFFE_0000; ovf_tab[0] = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4'b0001);
    waitAccept(0, 10);
    @(posedge clk); #1;
    applyStimulus(4'b0000);
    waitResp(10);
    checkOutput("sticky_before", 32'(ovf_sticky), 32'd0);
    @(negedge clk);
    checkOutput("sticky_set", 32'(ovf_sticky), 32'd1);

    @(posedge clk); #1;
    applyStimulus(4'b0001);
    waitAccept(0, 10);
    @(posedge clk); #1;
    applyStimulus(4'b0000);
    waitResp(10);
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    @(negedge clk);
    checkOutput("sticky_set_wins", 32'(ovf_sticky), 32'd1);
    @(posedge clk); #1;
    ovf_clear = 1'b1;
    @(posedge clk); #1;
    ovf_clear = 1'b0;
    @(negedge clk);
    checkOutput("sticky_clear", 32'(ovf_sticky), 32'd0);
    waitDrain(20);
    loadNormalTables();

    // Reset with both stages full under stall
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    applyStimulus(4'b1111);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("pre_reset_busy", 32'(busy), 32'd1);
    checkOutput("pre_reset_resp_valid", 32'(bus.resp_valid), 32'd1);
    @(posedge clk); #1;
    reset = 1'b1;
    applyStimulus(4'b1001);
    sb.delete();
    @(posedge clk); #1;
    reset     = 1'b0;
    model_ptr = 3;
    @(negedge clk);
    checkOutput("post_reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("post_reset_busy", 32'(busy), 32'd0);
    checkOutput("post_reset_req_ready", 32'(bus.req_ready), 32'b0001);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    applyStimulus(4'b0000);
    waitDrain(20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
